// File: rtl/serial_adder_core_if.sv
// Operand/result handshake bundle for serial_adder_core.
// With SERIAL_ADDER_ADDSUB_EN defined, a per-request subtract select is carried too.
interface serial_adder_core_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_ADDSUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

`ifdef SERIAL_ADDER_ADDSUB_EN
  modport master (output in_valid, a, b, cin, sub, out_ready,
                  input  in_ready, out_valid, sum, cout, ovf);
  modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                  output in_ready, out_valid, sum, cout, ovf);
`else
  modport master (output in_valid, a, b, cin, out_ready,
                  input  in_ready, out_valid, sum, cout, ovf);
  modport slave  (input  in_valid, a, b, cin, out_ready,
                  output in_ready, out_valid, sum, cout, ovf);
`endif
endinterface

// File: rtl/serial_adder_core.sv
// Multi-cycle adder: BITS_PER_CYCLE bits per clock, registered carry, valid/ready in and out.
// Optional macro SERIAL_ADDER_ADDSUB_EN adds a sub select (a - b via ~b plus carry-in 1).
module serial_adder_half (
  input  logic i_x,
  input  logic i_y,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_x ^ i_y;
  assign o_c = i_x & i_y;
endmodule

module serial_adder_full (
  input  logic i_x,
  input  logic i_y,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  logic w_s0, w_c0, w_c1;

  serial_adder_half u_h0 (.i_x(i_x),  .i_y(i_y), .o_s(w_s0), .o_c(w_c0));
  serial_adder_half u_h1 (.i_x(w_s0), .i_y(i_c), .o_s(o_s),  .o_c(w_c1));
  assign o_c = w_c0 | w_c1;
endmodule

module serial_adder_core #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                clk,
  input  logic                rst,
  serial_adder_core_if.slave  bus
);
  localparam int BPC   = (BITS_PER_CYCLE < 1) ? 1 : BITS_PER_CYCLE;
  localparam int STEPS = WIDTH / BPC;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (WIDTH < 2 || BITS_PER_CYCLE < 1 || (WIDTH % BPC) != 0) begin : g_bad_param
    $error("serial_adder_core: WIDTH must be >= 2 and divisible by BITS_PER_CYCLE");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a, r_b, r_acc, r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry, r_cout, r_ovf, r_out_valid;

  logic [BPC-1:0]   w_s;
  logic [BPC:0]     w_c;
  logic [WIDTH-1:0] w_acc_nxt;

  assign w_c[0] = r_carry;

  // One full adder per bit of the per-cycle slice; carry ripples across the slice.
  serial_adder_full u_fa [BPC-1:0] (
    .i_x (r_a[BPC-1:0]),
    .i_y (r_b[BPC-1:0]),
    .i_c (w_c[BPC-1:0]),
    .o_s (w_s),
    .o_c (w_c[BPC:1])
  );

  // New slice enters at the MSB end; after STEPS cycles the first slice sits at bit 0.
  assign w_acc_nxt = WIDTH'({w_s, r_acc} >> BPC);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_a     <= bus.a;
`ifdef SERIAL_ADDER_ADDSUB_EN
            r_b     <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.sub | bus.cin;
`else
            r_b     <= bus.b;
            r_carry <= bus.cin;
`endif
            r_cnt   <= '0;
            r_acc   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_a     <= r_a >> BPC;
          r_b     <= r_b >> BPC;
          r_carry <= w_c[BPC];
          r_acc   <= w_acc_nxt;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == CW'(STEPS - 1)) begin
            r_sum       <= w_acc_nxt;
            r_cout      <= w_c[BPC];
            r_ovf       <= w_c[BPC] ^ w_c[BPC-1];
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE) & ~rst;
  assign bus.out_valid = r_out_valid;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;
endmodule
